// File: rtl/if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Owns the PC and the req/ack fetch handshake.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   pc_write             1 = PC may advance
//   IF_ID_write          1 = IF/ID may load, 0 = hold (stall)
//   flush                redirect to target and kill IF/ID contents
//   pc_source            00 pc+4, 01 branch_target, 10 jump_target, 11 pc+4
//   branch_target        branch destination from decode
//   jump_target          jump destination from decode
//   imem_req/imem_addr   fetch request, address = pc
//   imem_ack/imem_rdata  request accepted, instruction valid same cycle
//   pc                   current fetch PC
//   if_id_instr          IF/ID instruction word
//   if_id_pc_plus4       IF/ID PC+4 of that instruction
//   if_id_valid          IF/ID holds a real instruction
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write,
    input  logic        IF_ID_write,
    input  logic        flush,
    input  logic [1:0]  pc_source,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid
);

    // HOLD: an acked word waits in hold_buf while decode is stalled.
    // DISCARD: a redirect arrived mid-fetch; the old request must
    // still complete, its data is thrown away.
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic [31:0] hold_buf;
    logic [31:0] pending;
    logic        advance;

    assign pc_plus4 = pc + 32'd4;
    assign advance  = IF_ID_write & pc_write;

    always_comb begin
        case (pc_source)
            2'b01:   target = branch_target;
            2'b10:   target = jump_target;
            default: target = pc_plus4;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            FETCH: begin
                if (flush)
                    state_nxt = imem_ack ? FETCH : DISCARD;
                else if (imem_ack && !advance)
                    state_nxt = HOLD;
            end
            HOLD: begin
                if (flush || advance) state_nxt = FETCH;
            end
            DISCARD: begin
                if (imem_ack) state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Outputs: address is always the current pc, so it stays stable
    // (the stale pc in DISCARD) until the request is acked.
    always_comb begin
        imem_req  = (state != HOLD);
        imem_addr = pc;
    end

    // PC, IF/ID register, hold buffer and pending redirect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
            hold_buf       <= 32'd0;
            pending        <= 32'd0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (flush) begin
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                        if (imem_ack) pc <= target;
                        else          pending <= target;
                    end else if (imem_ack) begin
                        if (advance) begin
                            if_id_instr    <= imem_rdata;
                            if_id_pc_plus4 <= pc_plus4;
                            if_id_valid    <= 1'b1;
                            pc             <= pc_plus4;
                        end else begin
                            hold_buf <= imem_rdata;
                        end
                    end else if (IF_ID_write) begin
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (flush) begin
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                        pc          <= target;
                    end else if (advance) begin
                        if_id_instr    <= hold_buf;
                        if_id_pc_plus4 <= pc_plus4;
                        if_id_valid    <= 1'b1;
                        pc             <= pc_plus4;
                    end
                end
                DISCARD: begin
                    // A newer redirect overrides the pending one.
                    if (flush) begin
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                        if (imem_ack) pc <= target;
                        else          pending <= target;
                    end else if (imem_ack) begin
                        pc <= pending;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
